// File: rtl/zeroriscy_perf_csr_reader.sv
// ---------------------------------------------------------------------------
// zeroriscy_perf_csr_reader
//
// Walks the performance counter registers (PCCR, CSR BASE_ADDR upward) through
// the core's CSR port and streams each value to a debug/trace consumer. When
// clear mode is latched at start, each counter is written to zero right after
// it has been read. The CSR port is shared through an external request/grant
// mux, so the request is dropped while a word waits on the output stream.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start_i, clear_i  start a snapshot (IDLE only) / clear-after-read mode
//   abort_i           abandon the snapshot, back to IDLE on the next edge
//   busy_o, done_o    non-IDLE indicator / one-cycle completion pulse
//   csr_req_o, csr_gnt_i, csr_access_o, csr_addr_o, csr_wdata_o, csr_op_o,
//   csr_rdata_i       CSR initiator port (op NONE=00 read, WRITE=01)
//   data_valid_o, data_ready_i, data_o, data_idx_o, data_last_o
//                     snapshot word stream
// ---------------------------------------------------------------------------
module zeroriscy_perf_csr_reader #(
    parameter int unsigned N_CNT     = 11,
    parameter logic [11:0] BASE_ADDR = 12'h780
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        clear_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        csr_req_o,
    input  logic        csr_gnt_i,
    output logic        csr_access_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    output logic [1:0]  csr_op_o,
    input  logic [31:0] csr_rdata_i,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    output logic [31:0] data_o,
    output logic [4:0]  data_idx_o,
    output logic        data_last_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CLEAR = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [4:0] LAST_IDX = 5'(N_CNT - 1);

    state_e     state_r;
    logic [4:0] idx_r;
    logic       clear_r;
    logic [4:0] idx_inc_s;
    logic       is_last_s;

    assign idx_inc_s    = idx_r + 5'd1;
    assign is_last_s    = (idx_r == LAST_IDX);
    // The access strobe is by definition the request itself.
    assign csr_access_o = csr_req_o;

    // Snapshot sequencer: state, counter index, clear mode and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            idx_r        <= 5'd0;
            clear_r      <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            csr_req_o    <= 1'b0;
            csr_addr_o   <= BASE_ADDR;
            csr_wdata_o  <= 32'd0;
            csr_op_o     <= OP_NONE;
            data_valid_o <= 1'b0;
            data_o       <= 32'd0;
            data_idx_o   <= 5'd0;
            data_last_o  <= 1'b0;
        end else if (abort_i && (state_r != S_IDLE)) begin
            // Abort wins over any grant/accept seen in the same cycle; a clear
            // that was granted earlier is not undone.
            state_r      <= S_IDLE;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            csr_req_o    <= 1'b0;
            csr_op_o     <= OP_NONE;
            csr_wdata_o  <= 32'd0;
            data_valid_o <= 1'b0;
            data_last_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        state_r     <= S_READ;
                        idx_r       <= 5'd0;
                        clear_r     <= clear_i;
                        busy_o      <= 1'b1;
                        csr_req_o   <= 1'b1;
                        csr_addr_o  <= BASE_ADDR;
                        csr_op_o    <= OP_NONE;
                        csr_wdata_o <= 32'd0;
                    end
                end
                S_READ: begin
                    if (csr_gnt_i) begin
                        data_o <= csr_rdata_i;
                        if (clear_r) begin
                            // Keep the port and turn the access into a zero write.
                            state_r     <= S_CLEAR;
                            csr_op_o    <= OP_WRITE;
                            csr_wdata_o <= 32'd0;
                        end else begin
                            state_r      <= S_SEND;
                            csr_req_o    <= 1'b0;
                            csr_op_o     <= OP_NONE;
                            data_valid_o <= 1'b1;
                            data_idx_o   <= idx_r;
                            data_last_o  <= is_last_s;
                        end
                    end
                end
                S_CLEAR: begin
                    if (csr_gnt_i) begin
                        state_r      <= S_SEND;
                        csr_req_o    <= 1'b0;
                        csr_op_o     <= OP_NONE;
                        csr_wdata_o  <= 32'd0;
                        data_valid_o <= 1'b1;
                        data_idx_o   <= idx_r;
                        data_last_o  <= is_last_s;
                    end
                end
                S_SEND: begin
                    if (data_ready_i) begin
                        data_valid_o <= 1'b0;
                        data_last_o  <= 1'b0;
                        if (is_last_s) begin
                            state_r <= S_DONE;
                            done_o  <= 1'b1;
                        end else begin
                            // Re-request the port for the next counter.
                            state_r    <= S_READ;
                            idx_r      <= idx_inc_s;
                            csr_req_o  <= 1'b1;
                            csr_addr_o <= BASE_ADDR + {7'd0, idx_inc_s};
                            csr_op_o   <= OP_NONE;
                        end
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_r      <= S_IDLE;
                    busy_o       <= 1'b0;
                    csr_req_o    <= 1'b0;
                    csr_op_o     <= OP_NONE;
                    data_valid_o <= 1'b0;
                    data_last_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zeroriscy_perf_csr_reader.sv
// ---------------------------------------------------------------------------
// Bench for zeroriscy_perf_csr_reader with three counters. A small CSR file
// model answers reads combinationally and takes writes; the reference for each
// snapshot is the list of counter values captured before the run.
// ---------------------------------------------------------------------------
module tb_zeroriscy_perf_csr_reader;

    localparam int          N    = 3;
    localparam logic [11:0] BASE = 12'h780;

    logic        clk = 1'b0;
    logic        rst, start_i, clear_i, abort_i, csr_gnt_i, data_ready_i;
    logic        busy_o, done_o, csr_req_o, csr_access_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o, csr_rdata_i, data_o;
    logic [1:0]  csr_op_o;
    logic        data_valid_o, data_last_o;
    logic [4:0]  data_idx_o;

    logic [31:0] mem [N];

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state (written only by the monitor process)
    logic [37:0] got_q[$];
    logic [11:0] rd_addr_q[$];
    logic [11:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int cyc = 0, done_cnt = 0, done_cyc = 0, proto_err = 0, stab_err = 0;
    logic        p_valid = 1'b0, p_ready = 1'b0, p_req = 1'b0, p_gnt = 1'b0, p_abort = 1'b0;
    logic [31:0] p_data = 32'd0;
    logic [4:0]  p_idx = 5'd0;
    logic [11:0] p_addr = 12'd0;
    logic [1:0]  p_op = 2'd0;

    // Stimulus knobs
    int g_pct = 100, r_pct = 100;
    int gstall_idx = -1, gstall_n = 0, rstall_idx = -1, rstall_n = 0, abort_idx = -1;
    bit busy_starts = 1'b0;

    zeroriscy_perf_csr_reader #(.N_CNT(N), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .csr_req_o(csr_req_o), .csr_gnt_i(csr_gnt_i),
        .csr_access_o(csr_access_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
        .csr_op_o(csr_op_o), .csr_rdata_i(csr_rdata_i), .data_valid_o(data_valid_o),
        .data_ready_i(data_ready_i), .data_o(data_o), .data_idx_o(data_idx_o),
        .data_last_o(data_last_o)
    );

    always #5 clk = ~clk;

    // CSR file read port: combinational, unknown addresses return a marker.
    always_comb begin
        csr_rdata_i = 32'hDEAD_BEEF;
        for (int i = 0; i < N; i++) begin
            if (csr_addr_o == BASE + 12'(i)) csr_rdata_i = mem[i];
        end
    end

    // Monitor: sample mid-cycle, log handshakes and protocol/stability violations.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid_o && data_ready_i && !abort_i)
                got_q.push_back({data_last_o, data_idx_o, data_o});
            if (done_o) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (csr_req_o && csr_gnt_i && !abort_i) begin
                if (csr_op_o == 2'b01) begin
                    wr_addr_q.push_back(csr_addr_o);
                    wr_data_q.push_back(csr_wdata_o);
                end else begin
                    rd_addr_q.push_back(csr_addr_o);
                end
            end
            if ((!csr_req_o && csr_op_o != 2'b00) || (csr_access_o !== csr_req_o) ||
                (data_valid_o && csr_req_o) || (csr_req_o && csr_op_o[1]))
                proto_err = proto_err + 1;
            if (p_valid && !p_ready && !p_abort &&
                (!data_valid_o || data_o !== p_data || data_idx_o !== p_idx))
                stab_err = stab_err + 1;
            if (p_req && !p_gnt && !p_abort &&
                (!csr_req_o || csr_addr_o !== p_addr || csr_op_o !== p_op))
                stab_err = stab_err + 1;
        end
        p_valid = data_valid_o; p_ready = data_ready_i; p_data = data_o; p_idx = data_idx_o;
        p_req = csr_req_o; p_gnt = csr_gnt_i; p_addr = csr_addr_o; p_op = csr_op_o;
        p_abort = abort_i;
        cyc = cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Issue one start and drive grant/ready/abort per the knobs until done, abort or budget.
    task automatic drive_snapshot(input logic clr, input int budget,
                                  output int lat, output bit timed_out, output bit aborted);
        int d0, t0, gleft, rleft;
        bit armed;
        d0 = done_cnt; gleft = gstall_n; rleft = rstall_n; armed = (abort_idx >= 0);
        aborted = 1'b0; timed_out = 1'b1; lat = -1;
        start_i = 1'b1; clear_i = clr; abort_i = 1'b0; csr_gnt_i = 1'b1; data_ready_i = 1'b1;
        @(posedge clk);
        t0 = cyc;
        #1;
        start_i = 1'b0; clear_i = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done_cnt != d0) begin
                timed_out = 1'b0; lat = done_cyc - t0; break;
            end
            if (aborted && !busy_o) begin
                timed_out = 1'b0; break;
            end
            csr_gnt_i = ($urandom_range(99) < g_pct);
            if (gleft > 0 && csr_req_o && csr_op_o == 2'b00 && csr_addr_o == BASE + 12'(gstall_idx)) begin
                csr_gnt_i = 1'b0; gleft--;
            end
            data_ready_i = ($urandom_range(99) < r_pct);
            if (rleft > 0 && data_valid_o && data_idx_o == 5'(rstall_idx)) begin
                data_ready_i = 1'b0; rleft--;
            end
            abort_i = 1'b0;
            if (armed && data_valid_o && data_idx_o == 5'(abort_idx)) begin
                abort_i = 1'b1; armed = 1'b0; aborted = 1'b1;
            end
            start_i = busy_starts ? 1'($urandom_range(1)) : 1'b0;
            clear_i = busy_starts;
            @(posedge clk);
            #1;
        end
        abort_i = 1'b0; start_i = 1'b0; clear_i = 1'b0; csr_gnt_i = 1'b1; data_ready_i = 1'b1;
    endtask

    // Apply CSR writes logged since index wr0 to the counter model.
    task automatic apply_writes(input int wr0);
        for (int i = wr0; i < wr_addr_q.size(); i++) begin
            if (int'(wr_addr_q[i] - BASE) < N) mem[int'(wr_addr_q[i] - BASE)] = wr_data_q[i];
        end
    endtask

    // One complete snapshot checked against the captured pre-run counter values.
    task automatic run_checked_snapshot(input string name, input logic clr, input int exp_lat);
        logic [31:0] pre [N];
        logic [37:0] exp_w;
        int w0, r0, wr0, p0, s0, d0, lat, nw;
        bit to, ab;
        for (int i = 0; i < N; i++) pre[i] = mem[i];
        w0 = got_q.size(); r0 = rd_addr_q.size(); wr0 = wr_addr_q.size();
        p0 = proto_err; s0 = stab_err; d0 = done_cnt;
        drive_snapshot(clr, 400, lat, to, ab);
        apply_writes(wr0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL %s timeout: got %0d required 0", name, to); end
        n_checks++;
        if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL %s done_count: got %0d required 1", name, done_cnt - d0); end
        if (exp_lat >= 0) begin
            n_checks++;
            if (lat !== exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat); end
        end
        nw = got_q.size() - w0;
        n_checks++;
        if (nw !== N) begin n_fail++; $display("FAIL %s word_count: got %0d required %0d", name, nw, N); end
        for (int i = 0; i < N && i < nw; i++) begin
            exp_w = {(i == N - 1), 5'(i), pre[i]};
            n_checks++;
            if (got_q[w0 + i] !== exp_w) begin
                n_fail++; $display("FAIL %s word%0d: got %h required %h", name, i, got_q[w0 + i], exp_w);
            end
        end
        n_checks++;
        if (rd_addr_q.size() - r0 !== N) begin n_fail++; $display("FAIL %s read_count: got %0d required %0d", name, rd_addr_q.size() - r0, N); end
        for (int i = 0; i < N && r0 + i < rd_addr_q.size(); i++) begin
            n_checks++;
            if (rd_addr_q[r0 + i] !== BASE + 12'(i)) begin
                n_fail++; $display("FAIL %s read_addr%0d: got %h required %h", name, i, rd_addr_q[r0 + i], BASE + 12'(i));
            end
        end
        n_checks++;
        if (wr_addr_q.size() - wr0 !== (clr ? N : 0)) begin
            n_fail++; $display("FAIL %s write_count: got %0d required %0d", name, wr_addr_q.size() - wr0, clr ? N : 0);
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (mem[i] !== (clr ? 32'd0 : pre[i])) begin
                n_fail++; $display("FAIL %s counter%0d_after: got %h required %h", name, i, mem[i], clr ? 32'd0 : pre[i]);
            end
        end
        if (clr) begin
            for (int i = 0; i < N && wr0 + i < wr_addr_q.size(); i++) begin
                n_checks++;
                if (wr_addr_q[wr0 + i] !== BASE + 12'(i)) begin
                    n_fail++; $display("FAIL %s write_addr%0d: got %h required %h", name, i, wr_addr_q[wr0 + i], BASE + 12'(i));
                end
            end
        end
        n_checks++;
        if (proto_err - p0 !== 0) begin n_fail++; $display("FAIL %s protocol: got %0d violations required 0", name, proto_err - p0); end
        n_checks++;
        if (stab_err - s0 !== 0) begin n_fail++; $display("FAIL %s stability: got %0d violations required 0", name, stab_err - s0); end
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL %s busy_after: got %b required 0", name, busy_o); end
    endtask

    task automatic check_idle_outputs(input string name);
        n_checks++;
        if ({busy_o, done_o, csr_req_o, csr_access_o, data_valid_o, data_last_o} !== 6'b0) begin
            n_fail++; $display("FAIL %s flags: got %b required 000000", name,
                               {busy_o, done_o, csr_req_o, csr_access_o, data_valid_o, data_last_o});
        end
        n_checks++;
        if (csr_addr_o !== BASE) begin n_fail++; $display("FAIL %s addr: got %h required %h", name, csr_addr_o, BASE); end
        n_checks++;
        if (csr_op_o !== 2'b00 || csr_wdata_o !== 32'd0) begin
            n_fail++; $display("FAIL %s op_wdata: got %b/%h required 00/0", name, csr_op_o, csr_wdata_o);
        end
        n_checks++;
        if (data_o !== 32'd0 || data_idx_o !== 5'd0) begin
            n_fail++; $display("FAIL %s data: got %h/%0d required 0/0", name, data_o, data_idx_o);
        end
    endtask

    task automatic test_reset();
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_basic();
        mem[0] = 32'h10; mem[1] = 32'h20; mem[2] = 32'h30;
        run_checked_snapshot("basic", 1'b0, 2 * N);
    endtask

    task automatic test_clear();
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        run_checked_snapshot("clear", 1'b1, 3 * N);
    endtask

    task automatic test_gnt_stall();
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        gstall_idx = 1; gstall_n = 5;
        run_checked_snapshot("gnt_stall", 1'b0, 2 * N + 5);
        gstall_idx = -1; gstall_n = 0;
    endtask

    task automatic test_ready_stall();
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        rstall_idx = 0; rstall_n = 4;
        run_checked_snapshot("ready_stall", 1'b0, 2 * N + 4);
        rstall_idx = -1; rstall_n = 0;
    endtask

    task automatic test_abort();
        logic [31:0] pre [N];
        int w0, wr0, d0, lat;
        bit to, ab;
        for (int i = 0; i < N; i++) begin mem[i] = $urandom | 32'h1; pre[i] = mem[i]; end
        w0 = got_q.size(); wr0 = wr_addr_q.size(); d0 = done_cnt;
        abort_idx = 1;
        drive_snapshot(1'b1, 200, lat, to, ab);
        abort_idx = -1;
        apply_writes(wr0);
        n_checks++;
        if (!ab || to) begin n_fail++; $display("FAIL abort_taken: got aborted=%b timeout=%b required 1/0", ab, to); end
        n_checks++;
        if (data_valid_o !== 1'b0 || csr_req_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_outputs: got valid=%b req=%b required 0/0", data_valid_o, csr_req_o);
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses required 0", done_cnt - d0); end
        n_checks++;
        if (wr_addr_q.size() - wr0 !== 2) begin n_fail++; $display("FAIL abort_writes: got %0d required 2", wr_addr_q.size() - wr0); end
        n_checks++;
        if (mem[0] !== 32'd0 || mem[1] !== 32'd0 || mem[2] !== pre[2]) begin
            n_fail++; $display("FAIL abort_counters: got %h %h %h required 0 0 %h", mem[0], mem[1], mem[2], pre[2]);
        end
        n_checks++;
        if (got_q.size() - w0 !== 1) begin n_fail++; $display("FAIL abort_words: got %0d required 1", got_q.size() - w0); end
        run_checked_snapshot("restart", 1'b0, 2 * N);
    endtask

    task automatic test_busy_start();
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        busy_starts = 1'b1;
        run_checked_snapshot("busy_start", 1'b0, 2 * N);
        busy_starts = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        start_i = 1'b1; clear_i = 1'b1; csr_gnt_i = 1'b0;
        @(posedge clk);
        #1;
        start_i = 1'b0; clear_i = 1'b0;
        @(posedge clk);
        #2;
        n_checks++;
        if (csr_req_o !== 1'b1) begin n_fail++; $display("FAIL mid_read_req: got %b required 1", csr_req_o); end
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_mid_read");
        #3;
        rst = 1'b0;
        csr_gnt_i = 1'b1;
        @(posedge clk);
        #1;
        run_checked_snapshot("after_reset", 1'b1, 3 * N);
    endtask

    task automatic test_random();
        bit clr;
        g_pct = 60; r_pct = 60;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) mem[i] = $urandom;
            clr = 1'($urandom_range(1));
            run_checked_snapshot($sformatf("random%0d", r), clr, -1);
        end
        g_pct = 100; r_pct = 100;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; clear_i = 1'b0; abort_i = 1'b0;
        csr_gnt_i = 1'b1; data_ready_i = 1'b1;
        for (int i = 0; i < N; i++) mem[i] = 32'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_clear();
        test_gnt_stall();
        test_ready_stall();
        test_abort();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
